// File: rtl/machine_timer_unit.sv
`default_nettype none
// ============================================================================
// Module      : machine_timer_unit
// Description : Memory-mapped RISC-V machine timer. A free-running 64-bit
//               mtime counter with a programmable prescaler is compared
//               against mtimecmp to produce a registered, level-sensitive
//               timer interrupt request for the CSR unit.
// Ports       : clk, rst                - clock, synchronous active-high reset
//               memAccessValid/WE       - register access request, 1 = write
//               memAccessOffset[4:0]    - byte offset in the timer window
//               memAccessWriteData[31:0]- write data
//               memReadData[31:0]       - read result (valid with memReadValid)
//               memReadValid            - one-cycle pulse, 1 cycle after read
//               reqTimerInterrupt       - timer interrupt request level
//               mtimeOut[63:0]          - current mtime for time/timeh CSRs
// Revision    : 1.0 - initial release
// ============================================================================
module machine_timer_unit #(
  parameter int PRESCALE_WIDTH = 8,
  parameter int RESET_PRESCALE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memAccessValid,
  input  logic        memAccessWE,
  input  logic [4:0]  memAccessOffset,
  input  logic [31:0] memAccessWriteData,
  output logic [31:0] memReadData,
  output logic        memReadValid,
  output logic        reqTimerInterrupt,
  output logic [63:0] mtimeOut
);

  // Word index within the window (offset[4:2])
  localparam logic [2:0] c_sel_mtime_lo = 3'd0;
  localparam logic [2:0] c_sel_mtime_hi = 3'd1;
  localparam logic [2:0] c_sel_cmp_lo   = 3'd2;
  localparam logic [2:0] c_sel_cmp_hi   = 3'd3;
  localparam logic [2:0] c_sel_ctrl     = 3'd4;

  localparam logic [PRESCALE_WIDTH-1:0] c_reset_div = PRESCALE_WIDTH'(RESET_PRESCALE);

  logic [63:0]               r_mtime;
  logic [63:0]               r_mtimecmp;
  logic                      r_enable;
  logic [PRESCALE_WIDTH-1:0] r_div;
  logic [PRESCALE_WIDTH-1:0] r_pre_cnt;
  logic [31:0]               r_hi_shadow;
  logic [31:0]               r_read_data;
  logic                      r_read_valid;
  logic                      r_irq;

  logic        w_aligned;
  logic [2:0]  w_sel;
  logic        w_rd;
  logic        w_wr;
  logic        w_tick;
  logic [31:0] w_ctrl_word;
  logic [31:0] w_rd_data;

  // Misaligned accesses are dropped, but a read still gets its valid pulse.
  assign w_aligned = (memAccessOffset[1:0] == 2'b00);
  assign w_sel     = memAccessOffset[4:2];
  assign w_rd      = memAccessValid && !memAccessWE;
  assign w_wr      = memAccessValid && memAccessWE && w_aligned;

  // mtime advances on the last prescaler count of each div+1 period.
  assign w_tick = r_enable && (r_pre_cnt == r_div);

  always_comb begin
    w_ctrl_word                       = '0;
    w_ctrl_word[0]                    = r_enable;
    w_ctrl_word[8 +: PRESCALE_WIDTH]  = r_div;
  end

  always_comb begin
    w_rd_data = '0;
    if (w_aligned) begin
      case (w_sel)
        c_sel_mtime_lo: w_rd_data = r_mtime[31:0];
        c_sel_mtime_hi: w_rd_data = r_hi_shadow;
        c_sel_cmp_lo:   w_rd_data = r_mtimecmp[31:0];
        c_sel_cmp_hi:   w_rd_data = r_mtimecmp[63:32];
        c_sel_ctrl:     w_rd_data = w_ctrl_word;
        default:        w_rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtime      <= '0;
      r_mtimecmp   <= '1;
      r_enable     <= 1'b1;
      r_div        <= c_reset_div;
      r_pre_cnt    <= '0;
      r_hi_shadow  <= '0;
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      r_read_valid <= w_rd;
      r_read_data  <= w_rd_data;

      // A LO read snapshots the upper half so a following HI read is
      // consistent with the LO value, even across a carry.
      if (w_rd && w_aligned && (w_sel == c_sel_mtime_lo)) begin
        r_hi_shadow <= r_mtime[63:32];
      end

      r_irq <= r_enable && (r_mtime >= r_mtimecmp);

      // Software writes win over the increment; the other half is untouched.
      if (w_wr && (w_sel == c_sel_mtime_lo)) begin
        r_mtime[31:0] <= memAccessWriteData;
      end else if (w_wr && (w_sel == c_sel_mtime_hi)) begin
        r_mtime[63:32] <= memAccessWriteData;
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
      end

      if (w_wr && (w_sel == c_sel_cmp_lo)) begin
        r_mtimecmp[31:0] <= memAccessWriteData;
      end
      if (w_wr && (w_sel == c_sel_cmp_hi)) begin
        r_mtimecmp[63:32] <= memAccessWriteData;
      end

      if (w_wr && (w_sel == c_sel_ctrl)) begin
        r_enable  <= memAccessWriteData[0];
        r_div     <= memAccessWriteData[8 +: PRESCALE_WIDTH];
        r_pre_cnt <= '0;
      end else if (r_enable) begin
        r_pre_cnt <= w_tick ? '0 : r_pre_cnt + PRESCALE_WIDTH'(1);
      end
    end
  end

  assign memReadData       = r_read_data;
  assign memReadValid      = r_read_valid;
  assign reqTimerInterrupt = r_irq;
  assign mtimeOut          = r_mtime;

endmodule
`default_nettype wire
